// File: rtl/rgb_pwm_generator.sv
// rgb_pwm_generator: three-channel LED PWM with shared prescaler and period-boundary double-buffered duty values
module rgb_pwm_generator #(
  parameter int PRESCALE   = 196,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] R_time_in,
  input  logic [7:0] G_time_in,
  input  logic [7:0] B_time_in,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       period_done
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] presc_q;
  logic [7:0]    cnt_q, sr_q, sg_q, sb_q;
  logic          tick, wrap, load;
  always_comb begin
    tick = en && presc_q == PW'(PRESCALE - 1);
    wrap = tick && cnt_q == 8'd254;
    load = !en || wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      sg_q        <= '0;
      sb_q        <= '0;
      led_r       <= ACTIVE_LOW;
      led_g       <= ACTIVE_LOW;
      led_b       <= ACTIVE_LOW;
      period_done <= 1'b0;
    end else begin
      presc_q     <= (!en || tick) ? '0 : presc_q + 1'b1;
      cnt_q       <= load ? '0 : tick ? cnt_q + 8'd1 : cnt_q;
      sr_q        <= load ? R_time_in : sr_q;
      sg_q        <= load ? G_time_in : sg_q;
      sb_q        <= load ? B_time_in : sb_q;
      led_r       <= (en && cnt_q < sr_q) ^ ACTIVE_LOW;
      led_g       <= (en && cnt_q < sg_q) ^ ACTIVE_LOW;
      led_b       <= (en && cnt_q < sb_q) ^ ACTIVE_LOW;
      period_done <= wrap;
    end
  end
endmodule

// File: tb/tb_rgb_pwm_generator.sv
// tb_rgb_pwm_generator: checks two PWM instances (PRESCALE=2 active-high, PRESCALE=1 active-low) against a phase-based model
module tb_rgb_pwm_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic [7:0] r_in = 8'hff, g_in = 8'hff, b_in = 8'hff;
  logic lr0, lg0, lb0, pd0, lr1, lg1, lb1, pd1;
  logic [3:0] o0, o1;
  int checks = 0, errors = 0;
  int pre[2] = '{2, 1};
  bit al[2] = '{1'b0, 1'b1};
  int ph[2];
  int d[2][3];
  logic [2:0] exp_led[2];
  logic exp_pd[2];
  bit live = 1'b0;
  int hc0[3], hc1[3], npd, first_pd;
  logic [2:0] first0;

  always #5 clk = ~clk;

  rgb_pwm_generator #(.PRESCALE(2), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
    .led_r(lr0), .led_g(lg0), .led_b(lb0), .period_done(pd0));
  rgb_pwm_generator #(.PRESCALE(1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
    .led_r(lr1), .led_g(lg1), .led_b(lb1), .period_done(pd1));

  assign o0 = {pd0, lb0, lg0, lr0};
  assign o1 = {pd1, lb1, lg1, lr1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: phase ph counts clks into the current period; step = ph / PRESCALE.
  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        ph[j] = 0;
        for (int i = 0; i < 3; i++) d[j][i] = 0;
        exp_led[j] = {3{al[j]}};
        exp_pd[j] = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) exp_led[j][i] = (en && (ph[j] / pre[j]) < d[j][i]) ^ al[j];
        exp_pd[j] = en && ph[j] == 255 * pre[j] - 1;
        if (!en || ph[j] == 255 * pre[j] - 1) begin
          ph[j] = 0;
          d[j][0] = r_in;
          d[j][1] = g_in;
          d[j][2] = b_in;
        end else ph[j]++;
      end
    end
    if (rst) live = 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_dut0", o0, {exp_pd[0], exp_led[0]});
      chk("model_dut1", o1, {exp_pd[1], exp_led[1]});
    end
  end

  task automatic window(input int n);
    for (int i = 0; i < 3; i++) begin hc0[i] = 0; hc1[i] = 0; end
    npd = 0;
    first_pd = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) first0 = {lb0, lg0, lr0};
      hc0[0] += lr0; hc0[1] += lg0; hc0[2] += lb0;
      hc1[0] += lr1; hc1[1] += lg1; hc1[2] += lb1;
      if (pd0) begin
        npd++;
        if (first_pd == 0) first_pd = k;
      end
    end
  endtask

  task automatic load(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    en = 1'b0;
    r_in = r; g_in = g; b_in = b;
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic wait_pd();
    int k = 0;
    @(negedge clk);
    while (!pd0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_pd_timeout", pd0, 1);
  endtask

  initial begin
    int a, k;
    repeat (3) begin
      @(negedge clk);
      chk("reset_dut0", o0, 4'b0000);
      chk("reset_dut1", o1, 4'b0111);
    end
    rst = 1'b0;

    load(8'hff, 8'h00, 8'h00);
    window(1020);
    chk("full_r_high", hc0[0], 1020);
    chk("zero_g_high", hc0[1], 0);
    chk("zero_b_high", hc0[2], 0);
    chk("full_pd_count", npd, 2);
    chk("full_pd_first", first_pd, 510);

    load(8'h7f, 8'h1f, 8'h61);
    wait_pd();
    window(510);
    chk("part_r_high", hc0[0], 254);
    chk("part_g_high", hc0[1], 62);
    chk("part_b_high", hc0[2], 194);
    chk("part_start_on", first0, 3'b111);
    chk("part_pd_at_end", first_pd, 510);

    load(8'h10, 8'h00, 8'h00);
    wait_pd();
    window(200);
    a = hc0[0];
    r_in = 8'hf0;
    window(310);
    chk("mid_cur_high", a + hc0[0], 32);
    window(510);
    chk("mid_next_high", hc0[0], 480);

    window(100);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_dut0", o0, 4'b0000);
    chk("en_off_dut1", o1, 4'b0111);
    window(9);
    chk("en_off_pd", npd, 0);
    chk("en_off_r", hc0[0], 0);
    en = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pd0 && k < 2000);
    chk("reen_pd_delay", k, 510);

    load(8'h00, 8'hff, 8'h80);
    window(255);
    chk("al_r_high", hc1[0], 255);
    chk("al_g_high", hc1[1], 0);
    chk("al_b_high", hc1[2], 127);

    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) r_in = 8'($urandom);
      if ($urandom_range(0, 49) == 0) g_in = 8'($urandom);
      if ($urandom_range(0, 49) == 0) b_in = 8'($urandom);
      if ($urandom_range(0, 199) == 0) r_in = $urandom_range(0, 1) ? 8'hff : 8'h00;
      if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      rst = $urandom_range(0, 999) == 0;
    end
    rst = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
